// File: rtl/node_irq_collector_pkg.sv
// Shared definitions for the node event collector.
//   arb_state_t    : grant FSM state encoding
//   N_CHANNELS_DEF : default number of collected event lines
package mopshub_irq_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;

  localparam int N_CHANNELS_DEF = 32;

endpackage

// File: rtl/node_irq_collector_if.sv
// Grant handshake between the collector and the bus-side consumer.
//   req_valid : a channel is being offered
//   req_idx   : offered channel, stable while req_valid is high
//   req_ack   : consumer accepts the offered channel
// master = collector side, slave = consumer side.
interface node_irq_collector_if #(
  parameter int IDX_W = 5
) ();
  logic             req_valid;
  logic [IDX_W-1:0] req_idx;
  logic             req_ack;

  modport master (output req_valid, output req_idx, input req_ack);
  modport slave  (input req_valid, input req_idx, output req_ack);
endinterface

// File: rtl/node_irq_collector_rr.sv
// Combinational round-robin pick over a request vector.
//   i_req : request bits
//   i_ptr : last granted channel; the search starts at i_ptr+1 and wraps
//   o_idx : winning channel (0 when nothing is requested)
//   o_any : at least one request bit is set
module rr_priority_pick #(
  parameter int N     = 32,
  parameter int IDX_W = 5
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_shift;
  logic [N-1:0]   w_rot;
  logic [IDX_W:0] w_off;
  logic [IDX_W:0] w_sum;

  // Rotating the doubled vector puts channel ptr+1 at bit 0, so a plain
  // lowest-set-bit search gives the wrapped round-robin order.
  assign w_dbl   = {i_req, i_req};
  assign w_shift = w_dbl >> ({1'b0, i_ptr} + (IDX_W+1)'(1));
  assign w_rot   = w_shift[N-1:0];

  always_comb begin
    o_any = 1'b0;
    w_off = '0;
    for (int j = N-1; j >= 0; j--) begin
      if (w_rot[j]) begin
        o_any = 1'b1;
        w_off = (IDX_W+1)'(j);
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, i_ptr} + (IDX_W+1)'(1) + w_off;
    if (w_sum >= (IDX_W+1)'(N)) w_sum = w_sum - (IDX_W+1)'(N);
    o_idx = o_any ? w_sum[IDX_W-1:0] : '0;
  end

endmodule

// File: rtl/node_irq_collector.sv
// Collects per-node event lines into sticky pending bits and offers them
// one at a time, round-robin, over a valid/ack grant interface.
//   clk, rst_n       : system clock, async active-low reset
//   i_irq_in         : raw event lines (synchronous)
//   i_mask           : 1 = channel may set pending
//   i_clear_all      : flush pending, overflow and arbitration state
//   o_data_tra_out   : registered level snapshot of i_irq_in
//   o_pend_out       : pending vector
//   o_overflow       : sticky, event hit an already pending channel
//   bus              : grant handshake (master side)
//
// state    | meaning
// ST_IDLE  | nothing offered; pick a winner when anything is pending
// ST_OFFER | req_idx offered, waiting for req_ack
module node_irq_collector
  import mopshub_irq_pkg::*;
#(
  parameter int N_CHANNELS = N_CHANNELS_DEF,
  parameter int IDX_W      = $clog2(N_CHANNELS),
  parameter bit EDGE_MODE  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CHANNELS-1:0] i_irq_in,
  input  logic [N_CHANNELS-1:0] i_mask,
  input  logic                  i_clear_all,
  output logic [N_CHANNELS-1:0] o_data_tra_out,
  output logic [N_CHANNELS-1:0] o_pend_out,
  output logic                  o_overflow,
  node_irq_collector_if.master  bus
);

  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_CHANNELS-1);

  logic [N_CHANNELS-1:0] r_s_q, r_s_prev, r_pend;
  logic                  r_overflow;
  logic [IDX_W-1:0]      r_ptr, r_req_idx;
  logic                  r_req_valid;
  arb_state_t            r_state;

  logic [N_CHANNELS-1:0] w_event, w_set, w_ack_clr;
  logic [IDX_W-1:0]      w_win;
  logic                  w_any;

  assign w_event   = EDGE_MODE ? (r_s_q & ~r_s_prev) : r_s_q;
  assign w_set     = w_event & i_mask;
  assign w_ack_clr = (r_req_valid && bus.req_ack) ? (N_CHANNELS'(1) << r_req_idx) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_q    <= '0;
      r_s_prev <= '0;
    end else begin
      r_s_q    <= i_irq_in;
      r_s_prev <= r_s_q;
    end
  end

  // A same-cycle set beats the ack clear, so a fresh event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend     <= '0;
      r_overflow <= 1'b0;
    end else if (i_clear_all) begin
      r_pend     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_ack_clr) | w_set;
      if (|(w_set & r_pend & ~w_ack_clr)) r_overflow <= 1'b1;
    end
  end

  rr_priority_pick #(.N(N_CHANNELS), .IDX_W(IDX_W)) u_pick (
    .i_req (r_pend),
    .i_ptr (r_ptr),
    .o_idx (w_win),
    .o_any (w_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req_valid <= 1'b0;
      r_req_idx   <= '0;
      r_ptr       <= PTR_RST;
    end else if (i_clear_all) begin
      r_state     <= ST_IDLE;
      r_req_valid <= 1'b0;
      r_ptr       <= PTR_RST;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_req_idx   <= w_win;
            r_req_valid <= 1'b1;
            r_state     <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (bus.req_ack) begin
            r_ptr       <= r_req_idx;
            r_req_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign o_data_tra_out = r_s_q;
  assign o_pend_out     = r_pend;
  assign o_overflow     = r_overflow;
  assign bus.req_valid  = r_req_valid;
  assign bus.req_idx    = r_req_idx;

endmodule

// File: tb/tb_node_irq_collector.sv
module tb_node_irq_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] irq_a, mask_a, data_a, pend_a;
  logic        clr_a, ovf_a;
  logic [31:0] irq_b, mask_b, data_b, pend_b;
  logic        clr_b, ovf_b;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];
  int m_ptr  = 31;

  node_irq_collector_if #(.IDX_W(5)) bus_a ();
  node_irq_collector_if #(.IDX_W(5)) bus_b ();

  node_irq_collector #(.N_CHANNELS(32), .IDX_W(5), .EDGE_MODE(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_irq_in(irq_a), .i_mask(mask_a),
    .i_clear_all(clr_a), .o_data_tra_out(data_a), .o_pend_out(pend_a),
    .o_overflow(ovf_a), .bus(bus_a)
  );

  node_irq_collector #(.N_CHANNELS(32), .IDX_W(5), .EDGE_MODE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_irq_in(irq_b), .i_mask(mask_b),
    .i_clear_all(clr_b), .o_data_tra_out(data_b), .o_pend_out(pend_b),
    .o_overflow(ovf_b), .bus(bus_b)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic vld(input bit sel);
    return sel ? bus_b.req_valid : bus_a.req_valid;
  endfunction

  function automatic logic [4:0] idx(input bit sel);
    return sel ? bus_b.req_idx : bus_a.req_idx;
  endfunction

  // Reference round-robin: queue the grant order for a batch of new pending bits.
  function automatic void push_order(input logic [31:0] bits);
    logic [31:0] b = bits;
    while (b != 0) begin
      for (int k = 1; k <= 32; k++) begin
        int c = (m_ptr + k) % 32;
        if (b[c]) begin
          exp_q.push_back(c);
          b[c]  = 1'b0;
          m_ptr = c;
          break;
        end
      end
    end
  endfunction

  task automatic wait_offer(input bit sel);
    int n = 0;
    int e;
    while (!vld(sel) && n < 30) begin
      tick();
      n++;
    end
    if (!vld(sel)) chk("offer_timeout", 64'd0, 64'd1);
    else if (exp_q.size() == 0) chk("sb_empty", 64'd0, 64'd1);
    else begin
      e = exp_q.pop_front();
      chk("grant_idx", 64'(idx(sel)), 64'(e));
    end
  endtask

  task automatic ack_grant(input bit sel);
    if (sel) bus_b.req_ack = 1'b1; else bus_a.req_ack = 1'b1;
    tick();
    bus_a.req_ack = 1'b0;
    bus_b.req_ack = 1'b0;
    chk("valid_drop", 64'(vld(sel)), 64'd0);
  endtask

  task automatic pulse_a(input logic [31:0] bits);
    irq_a = bits;
    tick();
    irq_a = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    irq_a = 32'hFFFF_FFFF; mask_a = 32'hFFFF_FFFF; clr_a = 1'b0;
    irq_b = '0;            mask_b = 32'h0000_0001; clr_b = 1'b0;
    bus_a.req_ack = 1'b0;
    bus_b.req_ack = 1'b0;

    // reset held with all lines high
    repeat (3) tick();
    chk("rst_data", 64'(data_a), 64'd0);
    chk("rst_pend", 64'(pend_a), 64'd0);
    chk("rst_valid", 64'(bus_a.req_valid), 64'd0);
    chk("rst_idx", 64'(bus_a.req_idx), 64'd0);
    chk("rst_ovf", 64'(ovf_a), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_data", 64'(data_a), 64'hFFFF_FFFF);
    chk("rel_pend0", 64'(pend_a), 64'd0);
    tick();
    chk("rel_pend", 64'(pend_a), 64'hFFFF_FFFF);
    irq_a = '0;
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    m_ptr = 31;
    chk("clr_pend", 64'(pend_a), 64'd0);
    chk("clr_valid", 64'(bus_a.req_valid), 64'd0);
    tick();

    // single event, 3-cycle latency
    push_order(32'h1 << 5);
    pulse_a(32'h1 << 5);
    tick();
    chk("lat_valid2", 64'(bus_a.req_valid), 64'd0);
    chk("lat_pend", 64'(pend_a), 64'(32'h1 << 5));
    tick();
    chk("lat_valid3", 64'(bus_a.req_valid), 64'd1);
    wait_offer(1'b0);
    ack_grant(1'b0);
    chk("single_pend", 64'(pend_a), 64'd0);

    // round robin from a fresh pointer
    clr_a = 1'b1; tick(); clr_a = 1'b0; m_ptr = 31;
    push_order((32'h1 << 3) | (32'h1 << 7) | (32'h1 << 30));
    pulse_a((32'h1 << 3) | (32'h1 << 7) | (32'h1 << 30));
    repeat (3) begin
      wait_offer(1'b0);
      ack_grant(1'b0);
    end
    // wrap: pointer now at 30
    push_order((32'h1 << 3) | (32'h1 << 30));
    pulse_a((32'h1 << 3) | (32'h1 << 30));
    repeat (2) begin
      wait_offer(1'b0);
      ack_grant(1'b0);
    end
    chk("rr_pend", 64'(pend_a), 64'd0);
    chk("rr_ovf", 64'(ovf_a), 64'd0);

    // collision on channel 9
    push_order(32'h1 << 9);
    pulse_a(32'h1 << 9);
    wait_offer(1'b0);
    pulse_a(32'h1 << 9);
    tick();
    chk("coll_ovf", 64'(ovf_a), 64'd1);
    chk("coll_hold_valid", 64'(bus_a.req_valid), 64'd1);
    chk("coll_hold_idx", 64'(bus_a.req_idx), 64'd9);
    // event lands on the same edge as the ack
    exp_q.push_back(9);
    irq_a = 32'h1 << 9;
    tick();
    irq_a = '0;
    ack_grant(1'b0);
    chk("coll_set_wins", 64'(pend_a[9]), 64'd1);
    wait_offer(1'b0);
    ack_grant(1'b0);
    chk("coll_pend", 64'(pend_a), 64'd0);

    // clear_all during an offer with a simultaneous ack
    clr_a = 1'b1; tick(); clr_a = 1'b0; m_ptr = 31;
    chk("clr_ovf_a", 64'(ovf_a), 64'd0);
    push_order(32'h1 << 12);
    pulse_a(32'h1 << 12);
    wait_offer(1'b0);
    pulse_a(32'h1 << 12);
    tick();
    chk("pre_clr_ovf", 64'(ovf_a), 64'd1);
    clr_a = 1'b1;
    bus_a.req_ack = 1'b1;
    tick();
    clr_a = 1'b0;
    bus_a.req_ack = 1'b0;
    m_ptr = 31;
    chk("offclr_pend", 64'(pend_a), 64'd0);
    chk("offclr_ovf", 64'(ovf_a), 64'd0);
    chk("offclr_valid", 64'(bus_a.req_valid), 64'd0);
    push_order((32'h1 << 2) | (32'h1 << 20));
    pulse_a((32'h1 << 2) | (32'h1 << 20));
    repeat (2) begin
      wait_offer(1'b0);
      ack_grant(1'b0);
    end

    // level mode, only channel 0 enabled
    irq_b = 32'h0000_0003;
    exp_q.push_back(0);
    wait_offer(1'b1);
    chk("lvl_pend", 64'(pend_b), 64'd1);
    ack_grant(1'b1);
    chk("lvl_repend", 64'(pend_b), 64'd1);
    exp_q.push_back(0);
    wait_offer(1'b1);
    mask_b = '0;
    tick();
    tick();
    chk("lvl_mask_keep", 64'(pend_b), 64'd1);
    chk("lvl_mask_valid", 64'(bus_b.req_valid), 64'd1);
    ack_grant(1'b1);
    chk("lvl_mask_clear", 64'(pend_b), 64'd0);
    tick();
    chk("lvl_no_offer", 64'(bus_b.req_valid), 64'd0);
    chk("lvl_data", 64'(data_b), 64'h3);

    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/node_irq_collector.md
# node_irq_collector

Parametrised successor to the 32-input node status register: collects N per-node event lines (IRQ / success / receive strobes from the CAN node blocks), registers them, optionally edge-detects them, latches them as sticky masked pending bits, and hands them one at a time to the bus-side controller through a valid/ack grant interface with round-robin fairness. It sits between the node receive/transmit controllers and the MOPSHUB bus arbitration logic. It keeps the old registered level snapshot output, so existing consumers of the 32-bit status bus still work.

## Interface
- N_CHANNELS, 32: number of event inputs, 2..64.
- IDX_W, $clog2(N_CHANNELS): width of the channel index.
- EDGE_MODE, 1: 1 = a rising edge sets pending; 0 = a high level sets pending.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- irq_in  in  N_CHANNELS  raw event lines, synchronous to clk.
- mask  in  N_CHANNELS  1 = channel enabled to set pending.
- clear_all  in  1  synchronous flush of pending, overflow and arbitration state.
- data_tra_out  out  N_CHANNELS  registered level snapshot of irq_in.
- pend_out  out  N_CHANNELS  current pending vector.
- req_valid  out  1  a grant is being offered.
- req_idx  out  IDX_W  channel being offered; stable while req_valid is high.
- req_ack  in  1  consumer accepts the offered channel.
- overflow  out  1  sticky flag: an event hit a channel that was already pending.

## Operation
- **Sample stage.** s_q <= irq_in every cycle. data_tra_out = s_q. s_prev <= s_q.
- **Event.** When EDGE_MODE=1, event = s_q & ~s_prev. When EDGE_MODE=0, event = s_q.
- **Set.** set_vec = event & mask. The mask only gates new sets; bits already pending are kept when their mask bit drops.
- **Pending update.** pend <= (pend & ~ack_clr) | set_vec.
  - ack_clr is the one-hot of req_idx when req_valid && req_ack.
  - If a set and an ack-clear hit the same channel in the same cycle, the set wins and the bit stays 1.
- **Overflow.** Set when (set_vec & pend & ~ack_clr) != 0. Cleared only by clear_all or reset.
- **Arbitration FSM, two states.**
  - IDLE: req_valid=0. If pend != 0, capture the round-robin winner into req_idx and go to OFFER.
  - OFFER: req_valid=1. On req_ack, clear that pend bit, set ptr <= req_idx, and go to IDLE. Without req_ack, stay in OFFER with req_idx held.
- **Round-robin search.** The winner is the first set bit of pend searching upward from ptr+1, wrapping from N_CHANNELS-1 to 0. ptr resets to N_CHANNELS-1, so the first search starts at channel 0.
- **clear_all.** Next cycle: pend=0, overflow=0, ptr=N_CHANNELS-1, FSM=IDLE, req_valid=0.
  - It overrides any same-cycle set_vec and req_ack.
  - s_q and s_prev keep sampling, so an edge in progress is not replayed.
- **Reset values.** data_tra_out=0, pend_out=0, req_valid=0, req_idx=0, overflow=0, FSM=IDLE. s_prev=0, so with EDGE_MODE=1 a line already high right after reset counts as one rising edge.
- **Reset mid-operation.** Asynchronous reset clears all state immediately. An offer that has not been acked is dropped.

## Timing
- Let irq_in rise before edge 0. Then s_q=1 after edge 0, pend=1 after edge 1, and req_valid=1 after edge 2. Event-to-offer latency is 3 cycles when the FSM is idle.
- data_tra_out lags irq_in by 1 cycle, the same as the legacy block.
- The ack handshake completes on the edge where req_valid && req_ack. req_valid is 0 for at least one cycle after every accept, giving at most one grant per 2 cycles.
- req_ack while req_valid=0 is ignored.
- pend_out, req_idx and overflow are registered outputs; there is no combinational path from any input to any output.

## Structure
- Shared package mopshub_irq_pkg holds:
  - the FSM state encoding (ST_IDLE, ST_OFFER);
  - the default N_CHANNELS = 32.
- One sub-module, rr_priority_pick (parameters N, IDX_W).
  - Inputs: req vector and ptr.
  - Outputs: winner index and any.
  - It is purely combinational and uses a doubled vector for the wrap search.
- The top level contains the sample registers, the pending/overflow logic and the FSM.

## Test plan
- **Reset.** Hold rst=0 with irq_in=32'hFFFF_FFFF. All outputs stay 0. Release rst with EDGE_MODE=1: pend_out=32'hFFFF_FFFF two cycles later.
- **Single event, N=32, mask all ones.** Pulse irq_in[5] for one cycle. Expect req_valid high 3 cycles later with req_idx=5. Ack: pend_out returns to 0 and req_valid drops the next cycle.
- **Round robin.** Make pend bits 3, 7 and 30 pending together. With ack every offer, the grant order is 3, 7, 30. Then re-set bits 3 and 30 after ptr=30: the order is 3, then 30, which checks the wrap.
- **Collision.** While channel 9 is pending, pulse irq_in[9] again: overflow=1. Pulse irq_in[9] in the same cycle as the ack of channel 9: pend_out[9] stays 1 and a new offer of channel 9 follows.
- **Mask and level mode.** With EDGE_MODE=0 and mask=32'h0000_0001:
  - irq_in=32'h0000_0003 held high sets only bit 0, and bit 0 re-pends after every ack.
  - Clearing mask[0] while bit 0 is pending keeps it pending.
- **clear_all during OFFER with a simultaneous ack.** pend_out=0, overflow=0 and req_valid=0 the next cycle, and the next grant search starts at channel 0.
